// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: dealer-arbiter state encoding, rank constants
// and the rank-to-value mapping also used by the sum/score logic.
package blackjack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    READ    = 2'd2,
    HOLD    = 2'd3
  } arb_state_t;

  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_TEN  = 4'd10;
  localparam logic [3:0] RANK_KING = 4'd13;

  function automatic logic rank_is_valid(input logic [3:0] rank);
    return (rank >= RANK_ACE) && (rank <= RANK_KING);
  endfunction

  // Face cards count as ten; anything outside A..K is a corrupt deck entry worth nothing.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    logic [3:0] value;
    if (!rank_is_valid(rank)) begin
      value = 4'd0;
    end else if (rank >= RANK_TEN) begin
      value = RANK_TEN;
    end else begin
      value = rank;
    end
    return value;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side that did not win last
// time gets the grant. The history only advances when the arbiter is enabled.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_player,
  input  logic req_dealer,
  output logic grant_valid,
  output logic grant_dealer
);

  logic last_grant;

  always_comb begin
    grant_valid  = req_player | req_dealer;
    grant_dealer = (req_player && req_dealer) ? ~last_grant : req_dealer;
  end

  // Reset to dealer so the player takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && grant_valid) begin
      last_grant <= grant_dealer;
    end
  end

endmodule

// File: rtl/card_dealer_arb.sv
// Shares the shuffled-deck RAM between the player and dealer deal requests and
// returns each card over a level handshake. Optional per-side card counters: CARD_COUNT_EN.
module card_dealer_arb
  import blackjack_pkg::*;
#(
  parameter int DECK_SIZE  = 52,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_player,
  input  logic       deal_dealer,
  output logic       card_ready,
  output logic       card_to_dealer,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic       deck_rd_en,
  output logic [5:0] deck_addr,
  input  logic [3:0] deck_data,
  output logic       shuffle_req,
  input  logic       shuffle_done,
  output logic [5:0] deck_pos,
  output logic       busy,
`ifdef CARD_COUNT_EN
  input  logic       clear_counts,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
`endif
  output logic       deck_err
);

  localparam logic [5:0] DECK_LAST = 6'(DECK_SIZE);
  localparam logic [1:0] RD_LAST   = 2'(RD_LATENCY);

  arb_state_t state;
  arb_state_t next_state;

  logic       grant_valid;
  logic       grant_dealer;
  logic       capture;
  logic       granted_req;
  logic [1:0] rd_cnt;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .en           (state == IDLE),
    .req_player   (deal_player),
    .req_dealer   (deal_dealer),
    .grant_valid  (grant_valid),
    .grant_dealer (grant_dealer)
  );

  assign capture     = (state == READ) && (rd_cnt == RD_LAST);
  assign granted_req = card_to_dealer ? deal_dealer : deal_player;
  assign deck_addr   = deck_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The reshuffle is lazy: an empty deck is only noticed when the next grant arrives.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = (deck_pos == DECK_LAST) ? SHUFFLE : READ;
        end
      end
      SHUFFLE: begin
        if (shuffle_done) begin
          next_state = READ;
        end
      end
      READ: begin
        if (capture) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!granted_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    card_ready  = 1'b0;
    shuffle_req = 1'b0;
    deck_rd_en  = 1'b0;
    case (state)
      IDLE: ;
      SHUFFLE: begin
        busy        = 1'b1;
        shuffle_req = 1'b1;
      end
      READ: begin
        busy       = 1'b1;
        deck_rd_en = (rd_cnt == 2'd0);
      end
      HOLD: begin
        busy       = 1'b1;
        card_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // rd_cnt counts cycles since the strobe; the RAM answer is valid when it hits RD_LATENCY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= 2'd0;
    end else if (state != READ) begin
      rd_cnt <= 2'd0;
    end else if (!capture) begin
      rd_cnt <= rd_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_to_dealer <= 1'b0;
    end else if ((state == IDLE) && grant_valid) begin
      card_to_dealer <= grant_dealer;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deck_pos <= 6'd0;
    end else if ((state == SHUFFLE) && shuffle_done) begin
      deck_pos <= 6'd0;
    end else if (capture) begin
      deck_pos <= deck_pos + 6'd1;
    end
  end

  // Card outputs persist through IDLE so the sequencer can still read the last card.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_rank  <= 4'd0;
      card_value <= 4'd0;
      deck_err   <= 1'b0;
    end else if (capture) begin
      card_rank  <= deck_data;
      card_value <= rank_to_value(deck_data);
      if (!rank_is_valid(deck_data)) begin
        deck_err <= 1'b1;
      end
    end
  end

`ifdef CARD_COUNT_EN
  // A clear in the same cycle as a delivery wins, so the counts restart from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player_cards <= 4'd0;
      dealer_cards <= 4'd0;
    end else if (clear_counts) begin
      player_cards <= 4'd0;
      dealer_cards <= 4'd0;
    end else if (capture) begin
      if (card_to_dealer) begin
        if (dealer_cards != 4'd15) begin
          dealer_cards <= dealer_cards + 4'd1;
        end
      end else begin
        if (player_cards != 4'd15) begin
          player_cards <= player_cards + 4'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_card_dealer_arb.sv
// Scoreboard bench for card_dealer_arb: a transaction-level deck model predicts each
// delivered card while a separate monitor compares whatever the DUT presents.
module tb_card_dealer_arb;

  localparam int DECK   = 4;
  localparam int RDL    = 1;
  localparam int NDECKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal_player;
  logic       deal_dealer;
  logic       card_ready;
  logic       card_to_dealer;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic       deck_rd_en;
  logic [5:0] deck_addr;
  logic [3:0] deck_data;
  logic       shuffle_req;
  logic       shuffle_done;
  logic [5:0] deck_pos;
  logic       busy;
  logic       deck_err;
`ifdef CARD_COUNT_EN
  logic       clear_counts;
  logic [3:0] player_cards;
  logic [3:0] dealer_cards;
`endif

  card_dealer_arb #(.DECK_SIZE(DECK), .RD_LATENCY(RDL)) dut (
    .clk            (clk),
    .rst            (rst),
    .deal_player    (deal_player),
    .deal_dealer    (deal_dealer),
    .card_ready     (card_ready),
    .card_to_dealer (card_to_dealer),
    .card_rank      (card_rank),
    .card_value     (card_value),
    .deck_rd_en     (deck_rd_en),
    .deck_addr      (deck_addr),
    .deck_data      (deck_data),
    .shuffle_req    (shuffle_req),
    .shuffle_done   (shuffle_done),
    .deck_pos       (deck_pos),
    .busy           (busy),
`ifdef CARD_COUNT_EN
    .clear_counts   (clear_counts),
    .player_cards   (player_cards),
    .dealer_cards   (dealer_cards),
`endif
    .deck_err       (deck_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       owner;
    bit [3:0] rank;
    bit [3:0] value;
    int       pos_after;
    bit       err;
    int       shuffles;
  } exp_t;

  exp_t     sbq[$];
  bit [3:0] decks [NDECKS][DECK];
  int       cur_deck;
  int       npass  = 0;
  int       ntotal = 0;

  int m_pos      = 0;
  int m_deck     = 0;
  int m_shuffles = 0;
  bit m_last     = 1'b1;
  bit m_err      = 1'b0;
  int m_cnt [2]  = '{0, 0};

  // Deck RAM: ranks come from the pre-generated deck the shuffler last loaded.
  logic [3:0] pipe_d [RDL];
  always @(posedge clk) begin
    pipe_d[0] <= (int'(deck_addr) < DECK && cur_deck < NDECKS) ? decks[cur_deck][deck_addr[1:0]] : 4'd0;
    for (int i = 1; i < RDL; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign deck_data = pipe_d[RDL-1];

  task automatic checkOutput(input string name, input int actual, input int expected);
    ntotal++;
    if (actual == expected) npass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: next card of the current deck, new deck when the previous one ran out.
  function automatic void predict(input bit owner);
    exp_t e;
    int   r;
    if (m_pos == DECK) begin
      m_pos = 0;
      m_deck++;
      m_shuffles++;
    end
    r = int'(decks[m_deck][m_pos]);
    e.owner = owner;
    e.rank  = 4'(r);
    if (r < 1 || r > 13) begin
      e.value = 4'd0;
      m_err   = 1'b1;
    end else begin
      e.value = 4'((r > 10) ? 10 : r);
    end
    m_pos++;
    e.pos_after = m_pos;
    e.err       = m_err;
    e.shuffles  = m_shuffles;
    m_last      = owner;
    if (m_cnt[owner] < 15) m_cnt[owner]++;
    sbq.push_back(e);
  endfunction

  // Shuffler: answers a request after a random delay and swaps in the next deck.
  initial begin
    shuffle_done = 1'b0;
    cur_deck     = 0;
    forever begin
      @(negedge clk);
      if (shuffle_req) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        cur_deck++;
        shuffle_done = 1'b1;
        @(negedge clk);
        shuffle_done = 1'b0;
      end
    end
  end

  // Monitor: strobe/shuffle bookkeeping and a scoreboard pop on every new card.
  initial begin
    bit   prev_ready = 1'b0;
    bit   prev_shreq = 1'b0;
    int   shreq_rises = 0;
    int   last_addr = -1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (deck_rd_en) last_addr = int'(deck_addr);
      if (shuffle_req && !prev_shreq) shreq_rises++;
      if (card_ready && !prev_ready && !rst) begin
        checkOutput("card_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("card_to_dealer", int'(card_to_dealer), int'(e.owner));
          checkOutput("card_rank", int'(card_rank), int'(e.rank));
          checkOutput("card_value", int'(card_value), int'(e.value));
          checkOutput("deck_pos", int'(deck_pos), e.pos_after);
          checkOutput("deck_addr_strobe", last_addr, e.pos_after - 1);
          checkOutput("deck_err", int'(deck_err), int'(e.err));
          checkOutput("shuffle_count", shreq_rises, e.shuffles);
          checkOutput("busy_in_hold", int'(busy), 1);
        end
      end
      prev_ready = card_ready;
      prev_shreq = shuffle_req;
    end
  end

  task automatic setReq(input bit owner, input bit v);
    if (owner) deal_dealer = v;
    else deal_player = v;
  endtask

  task automatic waitReady(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (card_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, int'(ok), 1);
  endtask

  // Patterns: 0 player, 1 dealer, 2 tie, 3 dealer withdrawn early, 4 player withdrawn early.
  task automatic applyStimulus(input int pattern);
    bit o;
    bit f;
    case (pattern)
      0, 1: begin
        o = (pattern == 1);
        predict(o);
        setReq(o, 1'b1);
        waitReady("single_ready");
        setReq(o, 1'b0);
        @(negedge clk);
      end
      2: begin
        f = !m_last;
        predict(f);
        predict(!f);
        deal_player = 1'b1;
        deal_dealer = 1'b1;
        waitReady("tie_first_ready");
        setReq(f, 1'b0);
        @(negedge clk);
        waitReady("tie_second_ready");
        setReq(!f, 1'b0);
        @(negedge clk);
      end
      default: begin
        o = (pattern == 3);
        predict(o);
        setReq(o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        setReq(o, 1'b0);
        waitReady("withdraw_ready");
        @(negedge clk);
        checkOutput("withdraw_pulse_one_cycle", int'(card_ready), 0);
      end
    endcase
  endtask

  initial begin
    bit seen;
    decks[0][0] = 4'd12;
    decks[0][1] = 4'd0;
    decks[0][2] = 4'd1;
    decks[0][3] = 4'd13;
    for (int g = 1; g < NDECKS; g++)
      for (int i = 0; i < DECK; i++) decks[g][i] = 4'($urandom_range(1, 14));
    deal_player = 1'b0;
    deal_dealer = 1'b0;
`ifdef CARD_COUNT_EN
    clear_counts = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_card_ready", int'(card_ready), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_shuffle_req", int'(shuffle_req), 0);
    checkOutput("reset_deck_rd_en", int'(deck_rd_en), 0);
    checkOutput("reset_deck_pos", int'(deck_pos), 0);
    checkOutput("reset_deck_err", int'(deck_err), 0);
    checkOutput("reset_card_rank", int'(card_rank), 0);
    checkOutput("reset_card_value", int'(card_value), 0);
    checkOutput("reset_card_to_dealer", int'(card_to_dealer), 0);
    rst = 1'b0;
    @(negedge clk);

    // First deal: strobe at cycle 1 with address 0, card presented at cycle 3.
    predict(1'b0);
    deal_player = 1'b1;
    @(negedge clk);
    checkOutput("lat_rd_en_cycle1", int'(deck_rd_en), 1);
    checkOutput("lat_addr_cycle1", int'(deck_addr), 0);
    @(negedge clk);
    checkOutput("lat_not_ready_cycle2", int'(card_ready), 0);
    @(negedge clk);
    checkOutput("lat_ready_cycle3", int'(card_ready), 1);
    deal_player = 1'b0;
    @(negedge clk);

    applyStimulus(3);
    applyStimulus(0);
    applyStimulus(2);
    applyStimulus(2);
    for (int n = 0; n < 60; n++) applyStimulus(int'($urandom_range(0, 4)));
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);

`ifdef CARD_COUNT_EN
    checkOutput("player_cards", int'(player_cards), m_cnt[0]);
    checkOutput("dealer_cards", int'(dealer_cards), m_cnt[1]);
    predict(1'b0);
    void'(sbq.pop_back());
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    deal_player = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = deck_rd_en;
    end
    checkOutput("clear_strobe_seen", int'(seen), 1);
    repeat (RDL) @(negedge clk);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    checkOutput("clear_hold_entry", int'(card_ready), 1);
    checkOutput("clear_player_cards", int'(player_cards), m_cnt[0]);
    checkOutput("clear_dealer_cards", int'(dealer_cards), m_cnt[1]);
    deal_player = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Reset while a read is in flight.
    deal_dealer = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = deck_rd_en;
    end
    checkOutput("midreset_strobe_seen", int'(seen), 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_deck_pos", int'(deck_pos), 0);
    checkOutput("midreset_card_rank", int'(card_rank), 0);
    checkOutput("midreset_rd_en", int'(deck_rd_en), 0);
    checkOutput("midreset_shuffle_req", int'(shuffle_req), 0);
    deal_dealer = 1'b0;
    @(negedge clk);
    checkOutput("midreset_card_ready", int'(card_ready), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
